// File: rtl/dino_pkg.sv
// Shared types and constants for the dino sprite motion/animation path.
package dino_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    DEAD = 2'd3
  } dino_state_t;

  localparam logic [8:0]  GROUND_Y      = 9'd335;
  localparam logic [8:0]  SPRITE_H      = 9'd60;
  localparam logic [8:0]  REST_Y        = GROUND_Y - SPRITE_H;
  localparam logic [12:0] SPRITE_PIXELS = 13'd3600;

  localparam logic [4:0]  JUMP_V0       = 5'd12;
  localparam logic [4:0]  GRAVITY       = 5'd1;
  localparam logic [4:0]  VMAX          = 5'd15;
  localparam logic [4:0]  JUMP_CUT_V    = 5'd4;
  localparam logic [2:0]  ANIM_DIV      = 3'd6;

  localparam logic [1:0]  RUN0          = 2'd0;
  localparam logic [1:0]  RUN1          = 2'd1;
  localparam logic [1:0]  AIR           = 2'd2;

endpackage

// File: rtl/dino_anim_seq.sv
// Run-cycle animation counter and sprite ROM base selection; updates on qualified ticks,
// base registered one cycle after the tick, no backpressure.
module dino_anim_seq
  import dino_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic        show_air,
  input  logic        clear,
  output logic [12:0] sprite_base
);

  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  frame_q, frame_d;
  logic [12:0] base_d;

  always_comb begin
    cnt_d   = cnt_q;
    frame_d = frame_q;
    if (clear) begin
      cnt_d   = 3'd0;
      frame_d = RUN0;
    end else if (show_air) begin
      frame_d = AIR;
    end else if (cnt_q == ANIM_DIV - 3'd1) begin
      cnt_d   = 3'd0;
      frame_d = (frame_q == RUN0) ? RUN1 : RUN0;
    end else begin
      cnt_d   = cnt_q + 3'd1;
    end
  end

  // frame*SPRITE_PIXELS as a constant mux rather than a multiplier
  always_comb begin
    case (frame_d)
      RUN1:    base_d = SPRITE_PIXELS;
      AIR:     base_d = SPRITE_PIXELS + SPRITE_PIXELS;
      default: base_d = 13'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= 3'd0;
      frame_q     <= RUN0;
      sprite_base <= 13'd0;
    end else if (step) begin
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      sprite_base <= base_d;
    end
  end

endmodule

// File: rtl/dino_motion_ctrl.sv
// Dino jump physics FSM and sprite position; state advances once per enabled frame tick,
// outputs registered. DINO_JUMP_CUT_EN enables variable jump height on early release.
module dino_motion_ctrl
  import dino_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic        jump,
  input  logic        collide,
  input  logic        restart,
  output logic [8:0]  sprite_y,
  output logic [12:0] sprite_base,
  output logic        airborne,
  output logic        dead
);

  dino_state_t state_q, state_d;
  logic [8:0]  y_q, y_d;
  logic [4:0]  vel_q, vel_d;
  logic [4:0]  rise_vel, fall_vel;
  logic [9:0]  y_wide;
  logic        tick;

  assign tick = frame_tick & enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      y_q     <= REST_Y;
      vel_q   <= 5'd0;
    end else if (tick) begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    vel_d    = vel_q;
    rise_vel = vel_q;
    fall_vel = vel_q;
    y_wide   = {1'b0, y_q};
    case (state_q)
      RUN: begin
        if (collide) begin
          state_d = DEAD;
        end else if (jump) begin
          state_d = RISE;
          vel_d   = JUMP_V0;
        end
      end
      RISE: begin
        if (collide) begin
          state_d = DEAD;
        end else begin
`ifdef DINO_JUMP_CUT_EN
          if (!jump && vel_q > JUMP_CUT_V) rise_vel = JUMP_CUT_V;
`endif
          y_wide = {1'b0, y_q} - {5'd0, rise_vel};
          y_d    = y_wide[9] ? 9'd0 : y_wide[8:0];
          vel_d  = rise_vel - GRAVITY;
          if (vel_d == 5'd0) state_d = FALL;
        end
      end
      FALL: begin
        if (collide) begin
          state_d = DEAD;
        end else begin
          fall_vel = (vel_q >= VMAX - GRAVITY) ? VMAX : vel_q + GRAVITY;
          y_wide   = {1'b0, y_q} + {5'd0, fall_vel};
          if (y_wide >= {1'b0, REST_Y}) begin
            y_d     = REST_Y;
            vel_d   = 5'd0;
            state_d = RUN;
          end else begin
            y_d     = y_wide[8:0];
            vel_d   = fall_vel;
          end
        end
      end
      DEAD: begin
        if (!collide && restart) begin
          state_d = RUN;
          y_d     = REST_Y;
          vel_d   = 5'd0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    airborne = (state_q == RISE) || (state_q == FALL);
    dead     = (state_q == DEAD);
    sprite_y = y_q;
  end

  // Entering RUN from any other state (landing or restart) restarts the run cycle.
  dino_anim_seq u_anim (
    .clk         (clk),
    .reset       (reset),
    .step        (tick),
    .show_air    (state_d != RUN),
    .clear       ((state_q != RUN) && (state_d == RUN)),
    .sprite_base (sprite_base)
  );

endmodule
